// File: rtl/exc_ctrl_pkg.sv
// Shared types for the exception controller: state encoding, ESR causes, MRS selects.
// Pure declarations; no timing and no flow control.
package exc_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'b00,
        HANDLER = 2'b01,
        FAULT   = 2'b10
    } exc_state_t;

    localparam logic [3:0] ESR_IRQ     = 4'b0001;
    localparam logic [3:0] ESR_INVOP   = 4'b0010;
    localparam logic [3:0] ESR_BADERET = 4'b0100;
    localparam logic [3:0] ESR_DFAULT  = 4'b1000;

    localparam logic [1:0] MRS_ELR  = 2'b00;
    localparam logic [1:0] MRS_ESR  = 2'b01;
    localparam logic [1:0] MRS_CNT  = 2'b10;
    localparam logic [1:0] MRS_ZERO = 2'b11;

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// Two-flop synchronizer for the external interrupt level; 2-cycle latency.
// No flow control: a level in, a level out.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// LEGv8 exception controller: same-cycle redirect/flush, ELR/ESR/irq_ack update at the edge.
// No backpressure; optional saturating entry counter under EXC_COUNT_EN.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int             N          = 64,
    parameter logic [N-1:0]   EXC_VECTOR = 64'h00000000000000D8,
    parameter int             CNT_W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc,
    input  logic         NotAnInstr,
    input  logic         ERet,
    input  logic         ext_irq,
    input  logic [1:0]   mrs_sel,
    output logic         exc_taken,
    output logic         exc_flush,
    output logic         eret_taken,
    output logic [N-1:0] Exc_vector,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         irq_ack,
    output logic         in_handler,
    output logic         halt,
    output logic [N-1:0] mrs_data
);

    exc_state_t       state;
    exc_state_t       state_nxt;
    logic [N-1:0]     elr_nxt;
    logic [3:0]       esr_nxt;
    logic             ack_nxt;
    logic             enter;
    logic             irq_s;
    logic [CNT_W-1:0] cnt_val;

    irq_sync u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_irq),
        .sync_out (irq_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= NORMAL;
            ELR     <= '0;
            ESR     <= '0;
            irq_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            ELR     <= elr_nxt;
            ESR     <= esr_nxt;
            irq_ack <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        elr_nxt    = ELR;
        esr_nxt    = ESR;
        ack_nxt    = 1'b0;
        enter      = 1'b0;
        exc_taken  = 1'b0;
        exc_flush  = 1'b0;
        eret_taken = 1'b0;
        case (state)
            NORMAL: begin
                // An ERET with no handler active is as illegal as a bad opcode.
                if (NotAnInstr || ERet) begin
                    exc_taken = 1'b1;
                    exc_flush = 1'b1;
                    elr_nxt   = pc;
                    esr_nxt   = NotAnInstr ? ESR_INVOP : ESR_BADERET;
                    state_nxt = HANDLER;
                    enter     = 1'b1;
                end else if (irq_s) begin
                    // The interrupted op retires, so the handler returns past it.
                    exc_taken = 1'b1;
                    elr_nxt   = pc + N'(4);
                    esr_nxt   = ESR_IRQ;
                    ack_nxt   = 1'b1;
                    state_nxt = HANDLER;
                    enter     = 1'b1;
                end
            end
            HANDLER: begin
                if (ERet) begin
                    eret_taken = 1'b1;
                    state_nxt  = NORMAL;
                end else if (NotAnInstr) begin
                    exc_flush = 1'b1;
                    esr_nxt   = ESR_DFAULT;
                    state_nxt = FAULT;
                    enter     = 1'b1;
                end
            end
            default: begin
                // FAULT, and the unused encoding, freeze the core until reset.
                exc_flush = 1'b1;
                state_nxt = FAULT;
            end
        endcase
    end

`ifdef EXC_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enter && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cnt_val = cnt;
`else
    logic unused_enter;

    assign unused_enter = enter;
    assign cnt_val      = '0;
`endif

    always_comb begin
        mrs_data = '0;
        case (mrs_sel)
            MRS_ELR: mrs_data = ELR;
            MRS_ESR: mrs_data[3:0] = ESR;
            MRS_CNT: mrs_data[CNT_W-1:0] = cnt_val;
            default: mrs_data = '0;
        endcase
    end

    assign Exc_vector = EXC_VECTOR;
    assign in_handler = (state == HANDLER);
    assign halt       = (state == FAULT);

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized and directed bench for exc_ctrl against an in-bench behavioural model.
module tb_exc_ctrl;

    localparam int CNT_MAX = 255;

    logic        clk;
    logic        reset;
    logic [63:0] pc;
    logic        NotAnInstr;
    logic        ERet;
    logic        ext_irq;
    logic [1:0]  mrs_sel;
    logic        exc_taken;
    logic        exc_flush;
    logic        eret_taken;
    logic [63:0] Exc_vector;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        irq_ack;
    logic        in_handler;
    logic        halt;
    logic [63:0] mrs_data;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = running, 1 = in handler, 2 = dead until reset.
    int          m_mode, n_mode;
    logic [63:0] m_elr, n_elr;
    logic [3:0]  m_esr, n_esr;
    bit          m_ack, n_ack;
    bit          m_s0, m_s1, n_s0, n_s1;
    int          m_cnt, n_cnt;

    exc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .NotAnInstr (NotAnInstr),
        .ERet       (ERet),
        .ext_irq    (ext_irq),
        .mrs_sel    (mrs_sel),
        .exc_taken  (exc_taken),
        .exc_flush  (exc_flush),
        .eret_taken (eret_taken),
        .Exc_vector (Exc_vector),
        .ELR        (ELR),
        .ESR        (ESR),
        .irq_ack    (irq_ack),
        .in_handler (in_handler),
        .halt       (halt),
        .mrs_data   (mrs_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode = 0; m_elr = '0; m_esr = '0; m_ack = 0;
        m_s0 = 0; m_s1 = 0; m_cnt = 0;
    endtask

    task automatic model_check();
        bit          e_taken, e_flush, e_eret;
        logic [63:0] e_mrs;
        e_taken = 0; e_flush = 0; e_eret = 0;
        if (m_mode == 0) begin
            e_taken = NotAnInstr || ERet || m_s1;
            e_flush = NotAnInstr || ERet;
        end else if (m_mode == 1) begin
            e_eret  = ERet;
            e_flush = !ERet && NotAnInstr;
        end else begin
            e_flush = 1;
        end
        case (mrs_sel)
            2'd0:    e_mrs = m_elr;
            2'd1:    e_mrs = {60'd0, m_esr};
`ifdef EXC_COUNT_EN
            2'd2:    e_mrs = 64'(m_cnt);
`endif
            default: e_mrs = '0;
        endcase
        chk("exc_taken",  64'(exc_taken),  64'(e_taken));
        chk("exc_flush",  64'(exc_flush),  64'(e_flush));
        chk("eret_taken", 64'(eret_taken), 64'(e_eret));
        chk("Exc_vector", Exc_vector, 64'hD8);
        chk("ELR",        ELR, m_elr);
        chk("ESR",        64'(ESR), 64'(m_esr));
        chk("irq_ack",    64'(irq_ack), 64'(m_ack));
        chk("in_handler", 64'(in_handler), 64'(m_mode == 1));
        chk("halt",       64'(halt), 64'(m_mode == 2));
        chk("mrs_data",   mrs_data, e_mrs);
    endtask

    task automatic model_next();
        bit entered;
        entered = 0;
        n_mode = m_mode; n_elr = m_elr; n_esr = m_esr; n_ack = 0; n_cnt = m_cnt;
        n_s0 = ext_irq; n_s1 = m_s0;
        if (m_mode == 0) begin
            if (NotAnInstr) begin
                n_elr = pc; n_esr = 4'd2; n_mode = 1; entered = 1;
            end else if (ERet) begin
                n_elr = pc; n_esr = 4'd4; n_mode = 1; entered = 1;
            end else if (m_s1) begin
                n_elr = pc + 64'd4; n_esr = 4'd1; n_ack = 1; n_mode = 1; entered = 1;
            end
        end else if (m_mode == 1) begin
            if (ERet) n_mode = 0;
            else if (NotAnInstr) begin
                n_esr = 4'd8; n_mode = 2; entered = 1;
            end
        end
        if (entered && n_cnt < CNT_MAX) n_cnt++;
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick(input bit pulse);
        #1;
        if (!reset) model_clear();
        model_check();
        model_next();
        @(posedge clk);
        #1;
        if (reset) begin
            m_mode = n_mode; m_elr = n_elr; m_esr = n_esr; m_ack = n_ack;
            m_s0 = n_s0; m_s1 = n_s1; m_cnt = n_cnt;
        end else begin
            model_clear();
        end
        if (pulse) begin
            #1 reset = 1'b0;
            #1 model_clear();
            chk("pulse_ELR",  ELR, 64'h0);
            chk("pulse_halt", 64'(halt), 64'h0);
            reset = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; pc = '0; NotAnInstr = 0; ERet = 0; ext_irq = 1; mrs_sel = 2'd0;
        model_clear();
        @(negedge clk);
        repeat (3) tick(0);
        #1;
        chk("rst_ELR", ELR, 64'h0);
        chk("rst_ESR", 64'(ESR), 64'h0);
        chk("rst_taken", 64'(exc_taken), 64'h0);

        // IRQ held across reset release surfaces in the third cycle.
        reset = 1'b1; pc = 64'h100;
        tick(0); tick(0);
        #1;
        chk("irq_3rd_cycle", 64'(exc_taken), 64'h1);
        chk("irq_no_flush", 64'(exc_flush), 64'h0);
        tick(0);
        chk("irq_ELR", ELR, 64'h104);
        chk("irq_ESR", 64'(ESR), 64'h1);
        chk("irq_ack_hi", 64'(irq_ack), 64'h1);
        chk("irq_in_handler", 64'(in_handler), 64'h1);
        ext_irq = 0;
        tick(0);
        chk("irq_ack_lo", 64'(irq_ack), 64'h0);
        tick(0);
        ERet = 1;
        #1 chk("irq_eret", 64'(eret_taken), 64'h1);
        tick(0);
        ERet = 0;

        // Invalid op and return.
        pc = 64'h40; NotAnInstr = 1;
        #1;
        chk("inv_taken", 64'(exc_taken), 64'h1);
        chk("inv_flush", 64'(exc_flush), 64'h1);
        tick(0);
        NotAnInstr = 0; mrs_sel = 2'd0;
        #1;
        chk("inv_ELR", ELR, 64'h40);
        chk("inv_ESR", 64'(ESR), 64'h2);
        chk("inv_in_handler", 64'(in_handler), 64'h1);
        chk("inv_mrs_elr", mrs_data, 64'h40);
        ERet = 1;
        #1 chk("inv_eret", 64'(eret_taken), 64'h1);
        tick(0);
        ERet = 0;
        chk("ret_ELR", ELR, 64'h40);
        chk("ret_in_handler", 64'(in_handler), 64'h0);

        // Invalid op beats a simultaneous IRQ; the IRQ is taken right after return.
        ext_irq = 1; pc = 64'h60;
        tick(0); tick(0);
        pc = 64'h80; NotAnInstr = 1;
        tick(0);
        NotAnInstr = 0;
        chk("prio_ESR", 64'(ESR), 64'h2);
        chk("prio_ELR", ELR, 64'h80);
        pc = 64'h200; ERet = 1;
        tick(0);
        ERet = 0; pc = 64'h300;
        #1 chk("pend_taken", 64'(exc_taken), 64'h1);
        tick(0);
        chk("pend_ESR", 64'(ESR), 64'h1);
        chk("pend_ELR", ELR, 64'h304);
        ext_irq = 0;
        tick(0); tick(0);
        ERet = 1;
        tick(0);
        ERet = 0;

        // Return address wraps at the top of the address space.
        ext_irq = 1;
        tick(0); tick(0);
        pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(0);
        chk("wrap_ELR", ELR, 64'h0);
        ext_irq = 0;
        tick(0); tick(0);
        ERet = 1;
        tick(0);
        ERet = 0;

        // Double fault is terminal until an asynchronous reset pulse.
        pc = 64'h500; NotAnInstr = 1;
        tick(0); tick(0);
        NotAnInstr = 0;
        chk("df_ESR", 64'(ESR), 64'h8);
        chk("df_halt", 64'(halt), 64'h1);
        ERet = 1;
        repeat (3) tick(0);
        ERet = 0;
        chk("df_stuck", 64'(halt), 64'h1);
        tick(1);
        chk("post_rst_ELR", ELR, 64'h0);
        chk("post_rst_halt", 64'(halt), 64'h0);
        chk("post_rst_in_handler", 64'(in_handler), 64'h0);

        // Counter saturation over 300 round trips.
        pc = 64'h700;
        for (int i = 0; i < 300; i++) begin
            NotAnInstr = 1;
            tick(0);
            NotAnInstr = 0; ERet = 1;
            tick(0);
            ERet = 0;
        end
        mrs_sel = 2'd2;
`ifdef EXC_COUNT_EN
        #1 chk("cnt_sat", mrs_data, 64'd255);
`else
        #1 chk("cnt_absent", mrs_data, 64'd0);
`endif
        tick(0);

        // Random traffic; faults are recovered with a reset pulse.
        for (int i = 0; i < 2500; i++) begin
            NotAnInstr = ($urandom % 10) == 0;
            ERet       = ($urandom % 7) == 0;
            if (($urandom % 12) == 0) ext_irq = ~ext_irq;
            if (($urandom % 16) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            else begin
                pc = {$urandom, $urandom};
                pc[1:0] = 2'b00;
            end
            mrs_sel = 2'($urandom % 4);
            tick((m_mode == 2) && (($urandom % 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
